countdown_display: RTL and testbench



---
 rtl/countdown_display.sv | 161 ++++++++++++++++
 tb/tb_countdown_display.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/countdown_display.sv
// countdown_display: binary-to-BCD conversion (sequential double-dabble)
// feeding a 3-digit multiplexed 7-segment scan.
// Optional build macro COUNTDOWN_DISPLAY_LZB_EN enables leading-zero blanking.
module countdown_display #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] count,
    input  logic       blank_n,
    input  logic       test_n,
    output logic [6:0] seg,
    output logic [2:0] dig_en,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    conv_state_t state;
    logic [19:0] shreg;
    logic [19:0] shreg_adj;
    logic [2:0]  bit_cnt;
    logic [7:0]  last_val;
    logic [3:0]  bcd_h;
    logic [3:0]  bcd_t;
    logic [3:0]  bcd_o;
    logic [7:0]  div_cnt;
    logic [1:0]  idx;
    logic [3:0]  digit;
    logic [2:0]  onehot;
    logic [6:0]  seg_norm;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    // Double-dabble add-3 correction on each BCD nibble before the shift
    always_comb begin
        shreg_adj = shreg;
        for (int unsigned i = 0; i < 3; i++) begin
            if (shreg[8 + 4*i +: 4] >= 4'd5)
                shreg_adj[8 + 4*i +: 4] = shreg[8 + 4*i +: 4] + 4'd3;
        end
    end

    // Conversion FSM: start on a new count, 8 shift steps, then commit digits
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            last_val <= '0;
            bcd_h    <= '0;
            bcd_t    <= '0;
            bcd_o    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != last_val) begin
                        shreg    <= {12'b0, count};
                        last_val <= count;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg_adj[18:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state <= COMMIT;
                end
                COMMIT: begin
                    bcd_h <= shreg[19:16];
                    bcd_t <= shreg[15:12];
                    bcd_o <= shreg[11:8];
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan divider and round-robin digit index 0->1->2->0
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Digit selection and decode for the currently scanned position
    always_comb begin
        digit  = bcd_o;
        onehot = 3'b001;
        case (idx)
            2'd1: begin
                digit  = bcd_t;
                onehot = 3'b010;
            end
            2'd2: begin
                digit  = bcd_h;
                onehot = 3'b100;
            end
            default: begin
                digit  = bcd_o;
                onehot = 3'b001;
            end
        endcase
        seg_norm = decode(digit);
`ifdef COUNTDOWN_DISPLAY_LZB_EN
        if (idx == 2'd2 && bcd_h == 4'd0)
            seg_norm = '0;
        if (idx == 2'd1 && bcd_h == 4'd0 && bcd_t == 4'd0)
            seg_norm = '0;
`endif
    end

    // Registered outputs: blank beats lamp test beats normal display
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            seg    <= '0;
            dig_en <= '0;
        end else if (!blank_n) begin
            seg    <= '0;
            dig_en <= '0;
        end else if (!test_n) begin
            seg    <= 7'h7F;
            dig_en <= onehot;
        end else begin
            seg    <= seg_norm;
            dig_en <= onehot;
        end
    end

endmodule

// File: tb/tb_countdown_display.sv
// Bench for countdown_display: two instances (SCAN_DIV=4 and SCAN_DIV=1)
// share stimulus and are checked against a timing-level behavioural model.
module tb_countdown_display;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] count;
    logic       blank_n;
    logic       test_n;
    logic [6:0] seg4, seg1;
    logic [2:0] dig4, dig1;
    logic       busy4, busy1;

    always #5 clk = ~clk;

    countdown_display #(.SCAN_DIV(4)) u_dut4 (
        .clk(clk), .clr(clr), .count(count), .blank_n(blank_n), .test_n(test_n),
        .seg(seg4), .dig_en(dig4), .busy(busy4)
    );

    countdown_display #(.SCAN_DIV(1)) u_dut1 (
        .clk(clk), .clr(clr), .count(count), .blank_n(blank_n), .test_n(test_n),
        .seg(seg1), .dig_en(dig1), .busy(busy1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: displayed value, last accepted input, cycles left in a conversion,
    // value being converted, and edges seen since reset release.
    int m_shown, m_last, m_left, m_pend, m_edges;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_shown = 0; m_last = 0; m_left = 0; m_pend = 0; m_edges = 0;
    endfunction

    function automatic logic [6:0] seg_code(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tbl[d];
    endfunction

    // Expected {dig_en, seg} for the next edge from the current model state
    function automatic logic [9:0] exp_out(input int sd);
        int pos, d;
        logic [6:0] s;
        pos = (m_edges / sd) % 3;
        if (!blank_n) return 10'd0;
        if (!test_n) return {3'(1 << pos), 7'h7F};
        d = (pos == 0) ? m_shown % 10 : (pos == 1) ? (m_shown / 10) % 10 : m_shown / 100;
        s = seg_code(d);
`ifdef COUNTDOWN_DISPLAY_LZB_EN
        if (pos == 2 && m_shown < 100) s = 7'h00;
        if (pos == 1 && m_shown < 10) s = 7'h00;
`endif
        return {3'(1 << pos), s};
    endfunction

    task automatic step();
        logic [9:0] e4, e1;
        @(posedge clk);
        if (clr) begin
            e4 = exp_out(4);
            e1 = exp_out(1);
            m_edges++;
            if (m_left == 0) begin
                if (int'(count) != m_last) begin
                    m_last = int'(count);
                    m_pend = int'(count);
                    m_left = 9;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_shown = m_pend;
            end
        end else begin
            e4 = '0;
            e1 = '0;
            model_reset();
        end
        #1;
        check("seg4",   16'(seg4),  16'(e4[6:0]));
        check("dig4",   16'(dig4),  16'(e4[9:7]));
        check("busy4",  16'(busy4), 16'(m_left > 0));
        check("seg1",   16'(seg1),  16'(e1[6:0]));
        check("dig1",   16'(dig1),  16'(e1[9:7]));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset asserted between edges: outputs must clear at once
    task automatic do_reset();
        clr = 1'b0;
        #1;
        check("rst_seg",  16'(seg4),  16'h0);
        check("rst_dig",  16'(dig4),  16'h0);
        check("rst_busy", 16'(busy4), 16'h0);
        model_reset();
        steps(2);
        clr = 1'b1;
    endtask

    initial begin
        clr = 1'b0; count = 8'd0; blank_n = 1'b1; test_n = 1'b1;
        model_reset();
        steps(2);
        clr = 1'b1;

        // Idle with count=0: scan only
        steps(30);
        // 0 -> 15
        count = 8'd15; steps(30);
        // 255, then 9 during the third shift step
        count = 8'd255; steps(3);
        count = 8'd9;   steps(40);
        // Blank and lamp-test priority
        count = 8'd7; blank_n = 1'b0; test_n = 1'b0; steps(20);
        blank_n = 1'b1; steps(15);
        test_n = 1'b1;  steps(15);
        // Reset in the middle of a conversion, then restart with 12
        count = 8'd200; steps(4);
        count = 8'd12;
        do_reset();
        steps(30);

        // Randomized segments
        for (int seg_i = 0; seg_i < 150; seg_i++) begin
            int r, len;
            r = int'($urandom_range(0, 9));
            if (r < 6) count = 8'($urandom);
            else if (r == 6) count = 8'($urandom_range(0, 20));
            blank_n = ($urandom_range(0, 7) != 0);
            test_n  = ($urandom_range(0, 5) != 0);
            len = int'($urandom_range(1, 25));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 15) == 0) count = 8'($urandom);
                step();
            end
            if ($urandom_range(0, 40) == 0) do_reset();
        end
        blank_n = 1'b1; test_n = 1'b1;
        steps(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
